// File: rtl/hazard_ctrl.sv
// Pipeline hazard/sequencing controller: stalls, flushes and the mult/div busy sequencer.
// Optional perf counters (stall_cycles, flush_cycles) enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int MULDIV_LATENCY = 32,
  parameter int CNT_W          = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       id_branch_rs,
  input  logic       id_reads_hilo,
  input  logic       id_is_muldiv,
  input  logic       id_ex_memread,
  input  logic       id_ex_regwrite,
  input  logic [4:0] id_ex_rd,
  input  logic       ex_mem_memread,
  input  logic [4:0] ex_mem_rd,
  input  logic       muldiv_start,
  input  logic       branch_taken,
  input  logic       jump,
  output logic       pc_write,
  output logic       if_id_write,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       muldiv_busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_cycles
`endif
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} mdState_t;

  mdState_t         state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;

  logic loadUse, brEx, brLd, mdHz, stall;

  // Mult/div busy sequencer: muldiv_busy is a direct decode of the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    case (state)
      IDLE: begin
        if (muldiv_start) begin
          stateNext = BUSY;
          cntNext   = CNT_W'(MULDIV_LATENCY - 1);
        end
      end
      BUSY: begin
        if (cnt != '0) cntNext = cnt - CNT_W'(1);
        else           stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign muldiv_busy = (state == BUSY);

  // Register $0 is excluded from every compare; it is never a real dependency.
  always_comb begin
    loadUse = id_ex_memread && (id_ex_rd != 5'd0) &&
              ((id_use_rs && (id_ex_rd == id_rs)) || (id_use_rt && (id_ex_rd == id_rt)));
    brEx    = id_branch_rs && id_ex_regwrite && (id_ex_rd != 5'd0) && (id_ex_rd == id_rs);
    brLd    = id_branch_rs && ex_mem_memread && (ex_mem_rd != 5'd0) && (ex_mem_rd == id_rs);
    mdHz    = muldiv_busy && (id_reads_hilo || id_is_muldiv);
    stall   = loadUse | brEx | brLd | mdHz;
  end

  // A stall suppresses any redirect: the branch operands are stale until the stall clears.
  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = branch_taken | jump;
    id_ex_flush = 1'b0;
    if (reset) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (stall) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_cycles <= '0;
    end else begin
      if (stall && (stall_cycles != 32'hFFFF_FFFF))
        stall_cycles <= stall_cycles + 32'd1;
      if (if_id_flush && (flush_cycles != 32'hFFFF_FFFF))
        flush_cycles <= flush_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: stall/flush decode, mult/div busy window, reset abort.
// Perf counter checks are included when HAZARD_PERF_CNT_EN is defined.
module tb_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] id_rs, id_rt, id_ex_rd, ex_mem_rd;
  logic       id_use_rs, id_use_rt, id_branch_rs, id_reads_hilo, id_is_muldiv;
  logic       id_ex_memread, id_ex_regwrite, ex_mem_memread;
  logic       muldiv_start, branch_taken, jump;

  logic pc_write, if_id_write, if_id_flush, id_ex_flush, muldiv_busy;
  logic pc_write32, if_id_write32, if_id_flush32, id_ex_flush32, muldiv_busy32;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_cycles, stall_cycles32, flush_cycles32;
`endif

  int errors = 0;
  int checks = 0;

  hazard_ctrl #(.MULDIV_LATENCY(4), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_branch_rs(id_branch_rs),
    .id_reads_hilo(id_reads_hilo), .id_is_muldiv(id_is_muldiv),
    .id_ex_memread(id_ex_memread), .id_ex_regwrite(id_ex_regwrite), .id_ex_rd(id_ex_rd),
    .ex_mem_memread(ex_mem_memread), .ex_mem_rd(ex_mem_rd),
    .muldiv_start(muldiv_start), .branch_taken(branch_taken), .jump(jump),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .muldiv_busy(muldiv_busy)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
`endif
  );

  hazard_ctrl #(.MULDIV_LATENCY(32), .CNT_W(6)) dut32 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_branch_rs(id_branch_rs),
    .id_reads_hilo(id_reads_hilo), .id_is_muldiv(id_is_muldiv),
    .id_ex_memread(id_ex_memread), .id_ex_regwrite(id_ex_regwrite), .id_ex_rd(id_ex_rd),
    .ex_mem_memread(ex_mem_memread), .ex_mem_rd(ex_mem_rd),
    .muldiv_start(muldiv_start), .branch_taken(branch_taken), .jump(jump),
    .pc_write(pc_write32), .if_id_write(if_id_write32), .if_id_flush(if_id_flush32),
    .id_ex_flush(id_ex_flush32), .muldiv_busy(muldiv_busy32)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(stall_cycles32), .flush_cycles(flush_cycles32)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    id_rs = 5'd0; id_rt = 5'd0; id_ex_rd = 5'd0; ex_mem_rd = 5'd0;
    id_use_rs = 1'b0; id_use_rt = 1'b0; id_branch_rs = 1'b0;
    id_reads_hilo = 1'b0; id_is_muldiv = 1'b0;
    id_ex_memread = 1'b0; id_ex_regwrite = 1'b0; ex_mem_memread = 1'b0;
    muldiv_start = 1'b0; branch_taken = 1'b0; jump = 1'b0;
  endtask

  // pc_write, if_id_write, if_id_flush, id_ex_flush of the latency-4 instance
  task automatic check_ctl(input string tag, input logic [3:0] exp);
    check(tag, {28'd0, pc_write, if_id_write, if_id_flush, id_ex_flush}, {28'd0, exp});
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;

    // Reset: held-reset outputs, then clean idle state
    @(negedge clk); #1;
    check_ctl("reset_outputs", 4'b0011);
    @(negedge clk); reset = 1'b0; #1;
    check("reset_busy", {31'd0, muldiv_busy}, 32'd0);
    check_ctl("idle_after_reset", 4'b1100);

    // Load-use on rs, then load moves to MEM (non-branch consumer: no stall)
    @(negedge clk); clear_inputs();
    id_ex_memread = 1'b1; id_ex_rd = 5'd8; id_rs = 5'd8; id_use_rs = 1'b1; #1;
    check_ctl("load_use_rs", 4'b0001);
    @(negedge clk); clear_inputs();
    ex_mem_memread = 1'b1; ex_mem_rd = 5'd8; id_rs = 5'd8; id_use_rs = 1'b1; #1;
    check_ctl("load_use_release", 4'b1100);
    @(negedge clk); clear_inputs();
    id_ex_memread = 1'b1; id_ex_rd = 5'd12; id_rt = 5'd12; id_use_rt = 1'b1; #1;
    check_ctl("load_use_rt", 4'b0001);
    @(negedge clk); clear_inputs();
    id_ex_memread = 1'b1; id_ex_rd = 5'd12; id_rs = 5'd12; id_rt = 5'd12; #1;
    check_ctl("load_match_unused", 4'b1100);

    // Load to $9 feeding a taken beq: two stalls, then the redirect
    @(negedge clk); clear_inputs();
    id_ex_memread = 1'b1; id_ex_regwrite = 1'b1; id_ex_rd = 5'd9;
    id_rs = 5'd9; id_use_rs = 1'b1; id_branch_rs = 1'b1; branch_taken = 1'b1; #1;
    check_ctl("br_load_stall1", 4'b0001);
    @(negedge clk); clear_inputs();
    ex_mem_memread = 1'b1; ex_mem_rd = 5'd9;
    id_rs = 5'd9; id_use_rs = 1'b1; id_branch_rs = 1'b1; branch_taken = 1'b1; #1;
    check_ctl("br_load_stall2", 4'b0001);
    @(negedge clk); clear_inputs();
    id_rs = 5'd9; id_use_rs = 1'b1; id_branch_rs = 1'b1; branch_taken = 1'b1; #1;
    check_ctl("br_redirect", 4'b1110);

    // ALU result in EX feeding a branch
    @(negedge clk); clear_inputs();
    id_ex_regwrite = 1'b1; id_ex_rd = 5'd5; id_rs = 5'd5; id_branch_rs = 1'b1; #1;
    check_ctl("br_ex_stall", 4'b0001);

    // $0 never matches
    @(negedge clk); clear_inputs();
    id_ex_regwrite = 1'b1; id_ex_rd = 5'd0; id_rs = 5'd0; id_use_rs = 1'b1; id_branch_rs = 1'b1; #1;
    check_ctl("jr_r0_no_stall", 4'b1100);
    @(negedge clk); clear_inputs();
    id_ex_memread = 1'b1; ex_mem_memread = 1'b1; id_rs = 5'd0; id_rt = 5'd0;
    id_use_rs = 1'b1; id_use_rt = 1'b1; id_branch_rs = 1'b1; #1;
    check_ctl("load_r0_no_stall", 4'b1100);

    // Jump: one flush cycle
    @(negedge clk); clear_inputs(); jump = 1'b1; #1;
    check_ctl("jump_flush", 4'b1110);
    @(negedge clk); clear_inputs(); #1;
    check_ctl("jump_done", 4'b1100);

    // Reset in cycle 2 of a 32-cycle mult/div aborts it
    @(negedge clk); clear_inputs(); muldiv_start = 1'b1; #1;
    check("md32_c0", {31'd0, muldiv_busy32}, 32'd0);
    @(negedge clk); clear_inputs(); #1;
    check("md32_c1", {31'd0, muldiv_busy32}, 32'd1);
    @(negedge clk); reset = 1'b1; #1;
    check("md32_c2", {31'd0, muldiv_busy32}, 32'd1);
    check_ctl("md32_reset_outputs", 4'b0011);
    @(negedge clk); reset = 1'b0; #1;
    check("md32_abort", {31'd0, muldiv_busy32}, 32'd0);
    check("md4_abort", {31'd0, muldiv_busy}, 32'd0);
    @(negedge clk); #1;
    check("md32_stays_idle", {31'd0, muldiv_busy32}, 32'd0);

    // Latency-4 mult/div: busy cycles 1..4, consumers held off, issue at cycle 5
    @(negedge clk); clear_inputs(); muldiv_start = 1'b1; #1;
    check("md4_c0", {31'd0, muldiv_busy}, 32'd0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk); clear_inputs();
      id_reads_hilo = c[0];
      id_is_muldiv  = ~c[0];
      muldiv_start  = (c == 2);
      #1;
      check($sformatf("md4_busy_c%0d", c), {31'd0, muldiv_busy}, 32'd1);
      check_ctl($sformatf("md4_stall_c%0d", c), 4'b0001);
    end
    @(negedge clk); clear_inputs(); id_reads_hilo = 1'b1; #1;
    check("md4_c5", {31'd0, muldiv_busy}, 32'd0);
    check_ctl("md4_issue", 4'b1100);

`ifdef HAZARD_PERF_CNT_EN
    @(negedge clk); clear_inputs(); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); clear_inputs();
      id_ex_memread = 1'b1; id_ex_rd = 5'd8; id_rs = 5'd8; id_use_rs = 1'b1;
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); clear_inputs(); jump = 1'b1;
    end
    @(negedge clk); clear_inputs(); #1;
    check("perf_stall", stall_cycles, 32'd3);
    check("perf_flush", flush_cycles, 32'd2);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0; #1;
    check("perf_stall_clr", stall_cycles, 32'd0);
    check("perf_flush_clr", flush_cycles, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
